ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries and maximum in-flight credits (power of 2, 2..16).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port imem_req_valid  output  1  fetch request valid.
REQ-006 Port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 Port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 Port imem_rsp_valid  input  1  response data valid; in-order, latency >= 1 cycle, no back-pressure.
REQ-009 Port imem_rsp_data  input  32  instruction word.
REQ-010 Port redirect_valid  input  1  one-cycle branch/jump redirect pulse.
REQ-011 Port redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-012 Port dec_valid  output  1  instruction available to decode.
REQ-013 Port dec_ready  input  1  decode consumes the head entry.
REQ-014 Port dec_instr  output  32  head instruction.
REQ-015 Port dec_pc  output  32  address of head instruction.

Function
REQ-016 The block SHALL hold a fetch PC register, a DEPTH-entry FIFO of {pc, instr}, an outstanding-request counter and a stale-drop counter.
REQ-017 A request handshake SHALL occur when imem_req_valid && imem_req_ready; imem_req_addr SHALL equal the fetch PC.
REQ-018 imem_req_valid SHALL be high only when !rst, !redirect_valid, and fifo_count + outstanding < DEPTH (credit rule; the FIFO can never overflow).
REQ-019 On each request handshake the fetch PC SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), and outstanding SHALL increment.
REQ-020 Request addresses SHALL be tracked in issue order so each accepted response is paired with its own PC.
REQ-021 A response with drop counter == 0 SHALL be written to the FIFO tail in the cycle it arrives and decrement outstanding; dec_valid for it SHALL assert no earlier than the next cycle.
REQ-022 A response with drop counter > 0 SHALL be discarded, decrementing both drop counter and outstanding.
REQ-023 A response arriving with outstanding == 0 SHALL be ignored with no state change.
REQ-024 dec_valid SHALL equal FIFO non-empty; dec_instr/dec_pc SHALL present the head entry and hold stable while dec_valid && !dec_ready.
REQ-025 The head SHALL be popped on dec_valid && dec_ready; push and pop in the same cycle SHALL be supported at any occupancy.
REQ-026 On redirect_valid: fetch PC <= {redirect_pc[31:2],2'b00}; FIFO cleared; drop counter <= outstanding after this cycle's response is accounted for; no request issued that cycle.
REQ-027 A decode handshake coincident with redirect SHALL be honoured (entry counted as consumed) before the flush; a response coincident with redirect SHALL be discarded.
REQ-028 A second redirect while the drop counter is nonzero SHALL reload the drop counter from the current outstanding count.
REQ-029 The first request after redirect SHALL be issued in the following cycle with imem_req_addr = new PC.

Reset
REQ-030 While rst is high: fetch PC = RESET_PC, FIFO empty, outstanding = 0, drop = 0, imem_req_valid = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0.
REQ-031 Responses and redirects during rst SHALL be ignored; reset mid-operation SHALL abandon all in-flight requests with no drop accounting afterward.
REQ-032 The first request SHALL be presented in the first cycle after rst deasserts, with address RESET_PC.

Verification
REQ-033 Reset release, memory always ready, 1-cycle latency, dec_ready=1 -> dec_pc sequence 0,4,8,12,... one per cycle after startup, dec_instr matching memory.
REQ-034 dec_ready=0 with fixed-latency memory -> exactly DEPTH (4) requests issued, then imem_req_valid=0; dec_valid stays high with dec_pc=0 stable until dec_ready rises.
REQ-035 Memory latency 3, redirect to 32'h0000_0103 while 3 requests are outstanding -> next request address 32'h0000_0100, 3 stale responses dropped, first decoded pc = 32'h0000_0100.
REQ-036 RESET_PC = 32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 Assert rst for one cycle with 2 requests outstanding and FIFO holding 2 entries -> dec_valid = 0 next cycle, late responses ignored, next request address = RESET_PC.
REQ-038 Redirect in the same cycle as a decode handshake and a response -> consumed entry not re-presented, response dropped, FIFO empty next cycle.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch unit bus bundle: imem request/response, redirect, decode handoff
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - credit-limited instruction fetch with in-order response buffer and redirect flush
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic        has_head;
  logic        credit_ok;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic        pop;
  logic [31:0] rsp_pc;

  assign has_head  = !rst && (count != '0);
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.dec_valid      = has_head;
  assign bus.dec_instr      = has_head ? fifo_instr[head] : 32'd0;
  assign bus.dec_pc         = has_head ? fifo_pc[head]    : 32'd0;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_take = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_take && !bus.redirect_valid && (drop == '0);
  assign pop      = has_head && bus.dec_ready;

  // Once stale responses are drained every in-flight request belongs to one
  // contiguous run ending just below fetch_pc, so the oldest one's address
  // falls out of the outstanding count without an address queue.
  assign rsp_pc = fetch_pc - 32'({outstanding, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~32'd3;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop     <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_take && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (rsp_keep) begin
          tail <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_pc[tail]    <= rsp_pc;
      fifo_instr[tail] <= bus.imem_rsp_data;
    end
  end
endmodule
